// File: rtl/scan_decoder.sv
// Registered N-to-2**N line decoder with a direct-select mode and an auto-scan
// mode that steps the index every DIV enabled cycles and pulses wrap on rollover.
module scan_decoder #(
    parameter int N          = 2,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DIV        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    a,
    input  logic            blank,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int M  = 2**N;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX     = PW'(DIV - 1);
    localparam logic [M-1:0]  INACTIVE = {M{ACTIVE_LOW}};

    logic [PW-1:0] presc, presc_nxt;
    logic [N-1:0]  idx_nxt;
    logic          prev_mode, mode_nxt;
    logic          wrap_nxt;
    logic [M-1:0]  dec, y_nxt;

    always_comb begin
        idx_nxt   = idx;
        presc_nxt = presc;
        mode_nxt  = prev_mode;
        wrap_nxt  = 1'b0;
        if (en) begin
            mode_nxt = mode;
            if (!mode || !prev_mode) begin
                // direct select, scan exit and scan entry all load the index from a
                idx_nxt   = a;
                presc_nxt = '0;
            end else if (presc == PMAX) begin
                presc_nxt = '0;
                idx_nxt   = idx + 1'b1;
                wrap_nxt  = (idx == {N{1'b1}});
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end
    end

    // y tracks the index being loaded this edge so y always matches decode(idx)
    always_comb begin
        dec          = '0;
        dec[idx_nxt] = 1'b1;
        if (blank)
            y_nxt = INACTIVE;
        else
            y_nxt = ACTIVE_LOW ? ~dec : dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= INACTIVE;
            idx       <= '0;
            wrap      <= 1'b0;
            presc     <= '0;
            prev_mode <= 1'b0;
        end else begin
            y         <= y_nxt;
            idx       <= idx_nxt;
            wrap      <= wrap_nxt;
            presc     <= presc_nxt;
            prev_mode <= mode_nxt;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder with N=2, ACTIVE_LOW=1, DIV=4.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst, en, mode, blank;
    logic [1:0] a;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    scan_decoder #(.N(2), .ACTIVE_LOW(1'b1), .DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .a     (a),
        .blank (blank),
        .y     (y),
        .idx   (idx),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ey, input logic [1:0] ei,
                           input logic ew);
        chk({tag, ".y"}, y, ey);
        chk({tag, ".idx"}, {2'b00, idx}, {2'b00, ei});
        chk({tag, ".wrap"}, {3'b000, wrap}, {3'b000, ew});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = 1'b0; a = 2'b00; blank = 1'b0;

        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1 chk_all("reset_async", 4'b1111, 2'b00, 1'b0);
        step();
        step();
        rst = 1'b0;
        chk_all("reset_hold", 4'b1111, 2'b00, 1'b0);

        // direct mode
        en = 1'b1; a = 2'b01;
        step(); chk_all("direct_01", 4'b1101, 2'b01, 1'b0);
        a = 2'b11;
        step(); chk_all("direct_11", 4'b0111, 2'b11, 1'b0);
        a = 2'b00;
        step(); chk_all("direct_00", 4'b1110, 2'b00, 1'b0);

        // scan entry at a=10, step every 4 cycles, wrap on 11->00
        a = 2'b10; mode = 1'b1;
        step(); chk_all("scan_entry", 4'b1011, 2'b10, 1'b0);
        a = 2'b01;
        for (int i = 1; i < 4; i++) begin
            step(); chk_all("scan_wait1", 4'b1011, 2'b10, 1'b0);
        end
        step(); chk_all("scan_step11", 4'b0111, 2'b11, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step(); chk_all("scan_wait2", 4'b0111, 2'b11, 1'b0);
        end
        step(); chk_all("scan_wrap", 4'b1110, 2'b00, 1'b1);
        step(); chk_all("wrap_one_cycle", 4'b1110, 2'b00, 1'b0);

        // prescaler now at 1; one more count reaches 2, then freeze
        step(); chk_all("hold_pre", 4'b1110, 2'b00, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_all("hold_frozen", 4'b1110, 2'b00, 1'b0);
        end
        en = 1'b1;
        step(); chk_all("hold_resume1", 4'b1110, 2'b00, 1'b0);
        step(); chk_all("hold_resume2", 4'b1101, 2'b01, 1'b0);

        // blank mid-scan: idx keeps stepping underneath
        blank = 1'b1;
        step(); chk_all("blank_on", 4'b1111, 2'b01, 1'b0);
        step(); chk_all("blank_p2", 4'b1111, 2'b01, 1'b0);
        step(); chk_all("blank_p3", 4'b1111, 2'b01, 1'b0);
        step(); chk_all("blank_step", 4'b1111, 2'b10, 1'b0);
        blank = 1'b0;
        step(); chk_all("blank_off", 4'b1011, 2'b10, 1'b0);

        // advance to idx=11 then abort with reset mid-cycle
        step(); chk_all("to11_a", 4'b1011, 2'b10, 1'b0);
        step(); chk_all("to11_b", 4'b1011, 2'b10, 1'b0);
        step(); chk_all("to11_c", 4'b0111, 2'b11, 1'b0);
        step(); chk_all("to11_d", 4'b0111, 2'b11, 1'b0);
        rst = 1'b1;
        #1 chk_all("abort_async", 4'b1111, 2'b00, 1'b0);
        a = 2'b01;
        step(); chk_all("abort_hold", 4'b1111, 2'b00, 1'b0);
        rst = 1'b0;
        step(); chk_all("reentry", 4'b1101, 2'b01, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step(); chk_all("reentry_wait", 4'b1101, 2'b01, 1'b0);
        end
        step(); chk_all("reentry_step", 4'b1011, 2'b10, 1'b0);

        // scan exit acts as direct decode on the same edge
        mode = 1'b0; a = 2'b11;
        step(); chk_all("scan_exit", 4'b0111, 2'b11, 1'b0);
        en = 1'b0; a = 2'b00;
        step(); chk_all("direct_en0", 4'b0111, 2'b11, 1'b0);
        blank = 1'b1;
        step(); chk_all("blank_en0", 4'b1111, 2'b11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter N, default 2: select width; output width is 2**N; legal N >= 1.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1: 1 means the selected line is 0 and others are 1; 0 means the inverse.
REQ-003 SHALL have parameter DIV, default 4: enabled cycles per scan step; legal DIV >= 1.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the sole clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  advance enable; 0 freezes all state.
REQ-007 SHALL have port mode  input  1  0 = direct decode of a; 1 = auto-scan.
REQ-008 SHALL have port a  input  N  select in direct mode; scan start index on scan entry.
REQ-009 SHALL have port blank  input  1  forces all y lines inactive.
REQ-010 SHALL have port y  output  2**N  registered decoded lines.
REQ-011 SHALL have port idx  output  N  registered current index.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse on scan wrap.

Function
REQ-013 SHALL register every output; no combinational path from any input to y, idx or wrap.
REQ-014 SHALL make y equal decode(idx) in every cycle, honouring ACTIVE_LOW, unless blanked.
REQ-015 SHALL apply the following in direct mode (mode=0, en=1): on each edge idx <= a and the prescaler clears; latency from a to y is 1 cycle.
REQ-016 SHALL apply the following on scan entry (mode 0->1 sampled with en=1): idx <= a, prescaler <= 0, wrap <= 0; the previous mode is tracked by an internal register.
REQ-017 SHALL apply the following in scan mode (mode=1, en=1, not scan entry): the prescaler counts 0..DIV-1; at DIV-1 it clears and idx <= idx+1 modulo 2**N.
REQ-018 SHALL assert wrap for exactly the one cycle following the step from 2**N-1 to 0; otherwise wrap is 0.
REQ-019 SHALL, with DIV=1, advance idx on every enabled scan cycle.
REQ-020 SHALL, with en=0, hold idx, prescaler, and the previous-mode register, clear wrap, and still update y from the blank state.
REQ-021 SHALL, on scan exit (mode 1->0 with en=1), behave as direct mode on that edge.
REQ-022 SHALL sample blank on every edge regardless of en: blank=1 drives y all-inactive on the next cycle; idx and the prescaler continue unaffected.
REQ-023 SHALL, on blank release, drive y to decode(current idx) on the next cycle.
REQ-024 SHALL let blank take priority over decode and let scan entry take priority over a prescaler step on the same edge.

Reset
REQ-025 SHALL, while rst=1, immediately and asynchronously force y all-inactive (all 1 if ACTIVE_LOW, all 0 otherwise), idx=0, wrap=0, prescaler=0 and previous-mode=0.
REQ-026 SHALL resume operation on the first rising clk edge after rst deasserts, treating mode=1 at that edge as scan entry.
REQ-027 SHALL abort any scan in progress on reset mid-operation, with no wrap pulse issued.

Verification (N=2, ACTIVE_LOW=1, DIV=4)
REQ-028 SHALL verify reset: assert rst between edges -> y=1111, idx=00, wrap=0 with no clock edge.
REQ-029 SHALL verify direct mode: mode=0, en=1, a=01 -> next cycle y=1101; a=11 -> y=0111; a=00 -> y=1110.
REQ-030 SHALL verify scan: mode 0->1 with a=10 -> idx=10, y=1011; 4 cycles later idx=11, y=0111; 4 more cycles later idx=00, y=1110, wrap=1 for exactly one cycle.
REQ-031 SHALL verify hold: in scan, drop en for 3 cycles after 2 prescaler counts -> idx and y frozen; the step occurs 2 enabled cycles after en returns.
REQ-032 SHALL verify blank: blank=1 mid-scan -> y=1111 next cycle while idx keeps stepping; blank=0 -> y=decode(idx) next cycle.
REQ-033 SHALL verify abort: rst pulse mid-scan at idx=11 -> y=1111, idx=00, no wrap pulse; with mode held at 1 -> scan re-enters at a.
